// File: rtl/acc_pipeline_core_if.sv
// Instruction stream from the fetch unit into acc_pipeline_core.
// Valid/ready: a transfer happens on a rising edge where instr_valid && instr_ready; payload must be stable while valid is high.
interface acc_pipeline_core_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
);
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_op;
  logic [REG_AW-1:0] instr_reg;
  logic [DATA_W-1:0] instr_imm;

  modport master (output instr_valid, instr_op, instr_reg, instr_imm, input instr_ready);
  modport slave  (input instr_valid, instr_op, instr_reg, instr_imm, output instr_ready);
endinterface

// File: rtl/acc_pipeline_core.sv
// Accumulator core: S1 decode latch, S2 execute into acc/flags/S3, S3 register writeback.
// S3 forwards its pending register write to the S2 operand read.
module acc_pipeline_core #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int PC_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  acc_pipeline_core_if.slave   instr,
  output logic [DATA_W-1:0]    acc,
  output logic                 cy,
  output logic                 z,
  output logic [PC_W-1:0]      pc,
  output logic                 retire_valid,
  output logic                 halted,
  output logic                 illegal,
  input  logic [REG_AW-1:0]    dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);
  localparam int NREGS = 1 << REG_AW;

  localparam logic [3:0] OP_NOP = 4'd0,  OP_MVI = 4'd1,  OP_MOVAR = 4'd2, OP_MOVRA = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4,  OP_SUB = 4'd5,  OP_ANA = 4'd6,   OP_ORA = 4'd7;
  localparam logic [3:0] OP_XRA = 4'd8,  OP_INR = 4'd9,  OP_DCR = 4'd10,  OP_ADI = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12, OP_LDI = 4'd13, OP_HLT = 4'd14,  OP_ILL = 4'd15;

  logic [DATA_W-1:0] rf [NREGS];

  logic              s1_valid;
  logic [3:0]        s1_op;
  logic [REG_AW-1:0] s1_reg;
  logic [DATA_W-1:0] s1_imm;

  logic              s3_valid;
  logic              s3_we;
  logic [REG_AW-1:0] s3_reg;
  logic [DATA_W-1:0] s3_data;

  logic              accept;
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   sum_ext, dif_ext, adi_ext;
  logic [DATA_W-1:0] inc_val, dec_val;

  logic [DATA_W-1:0] acc_n, wdata_n;
  logic              cy_n, z_n, wr_n, halt_n, ill_n;

  // HLT stops acceptance as soon as it sits in S1, so nothing younger enters.
  assign instr.instr_ready = !halted && !(s1_valid && s1_op == OP_HLT);
  assign accept            = instr.instr_valid && instr.instr_ready;

  assign operand  = (s3_valid && s3_we && s3_reg == s1_reg) ? s3_data : rf[s1_reg];
  assign sum_ext  = {1'b0, acc} + {1'b0, operand};
  assign dif_ext  = {1'b0, acc} - {1'b0, operand};
  assign adi_ext  = {1'b0, acc} + {1'b0, s1_imm};
  assign inc_val  = operand + DATA_W'(1);
  assign dec_val  = operand - DATA_W'(1);
  assign dbg_data = rf[dbg_addr];

  always_comb begin
    acc_n   = acc;
    cy_n    = cy;
    z_n     = z;
    wr_n    = 1'b0;
    wdata_n = '0;
    halt_n  = 1'b0;
    ill_n   = 1'b0;
    if (s1_valid) begin
      case (s1_op)
        OP_NOP:   ;
        OP_MVI:   acc_n = s1_imm;
        OP_MOVAR: acc_n = operand;
        OP_MOVRA: begin wr_n = 1'b1; wdata_n = acc; end
        OP_ADD:   begin acc_n = sum_ext[DATA_W-1:0]; cy_n = sum_ext[DATA_W]; z_n = (sum_ext[DATA_W-1:0] == '0); end
        OP_SUB:   begin acc_n = dif_ext[DATA_W-1:0]; cy_n = dif_ext[DATA_W]; z_n = (dif_ext[DATA_W-1:0] == '0); end
        OP_ANA:   begin acc_n = acc & operand; cy_n = 1'b0; z_n = ((acc & operand) == '0); end
        OP_ORA:   begin acc_n = acc | operand; cy_n = 1'b0; z_n = ((acc | operand) == '0); end
        OP_XRA:   begin acc_n = acc ^ operand; cy_n = 1'b0; z_n = ((acc ^ operand) == '0); end
        OP_INR:   begin wr_n = 1'b1; wdata_n = inc_val; z_n = (inc_val == '0); end
        OP_DCR:   begin wr_n = 1'b1; wdata_n = dec_val; z_n = (dec_val == '0); end
        OP_ADI:   begin acc_n = adi_ext[DATA_W-1:0]; cy_n = adi_ext[DATA_W]; z_n = (adi_ext[DATA_W-1:0] == '0); end
        OP_CMP:   begin cy_n = dif_ext[DATA_W]; z_n = (dif_ext[DATA_W-1:0] == '0); end
        OP_LDI:   begin wr_n = 1'b1; wdata_n = s1_imm; end
        OP_HLT:   halt_n = 1'b1;
        OP_ILL:   ill_n = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_op        <= '0;
      s1_reg       <= '0;
      s1_imm       <= '0;
      s3_valid     <= 1'b0;
      s3_we        <= 1'b0;
      s3_reg       <= '0;
      s3_data      <= '0;
      acc          <= '0;
      cy           <= 1'b0;
      z            <= 1'b0;
      pc           <= '0;
      retire_valid <= 1'b0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op  <= instr.instr_op;
        s1_reg <= instr.instr_reg;
        s1_imm <= instr.instr_imm;
        pc     <= pc + PC_W'(1);
      end
      acc      <= acc_n;
      cy       <= cy_n;
      z        <= z_n;
      halted   <= halted | halt_n;
      illegal  <= illegal | ill_n;
      s3_valid <= s1_valid;
      s3_we    <= s1_valid & wr_n;
      s3_reg   <= s1_reg;
      s3_data  <= wdata_n;
      retire_valid <= s3_valid;
      if (s3_valid && s3_we) rf[s3_reg] <= s3_data;
    end
  end
endmodule

// File: tb/tb_acc_pipeline_core.sv
// Directed bench for acc_pipeline_core: an 8-bit default instance and a 16-bit/16-reg/4-bit-pc instance.
module tb_acc_pipeline_core;
  localparam logic [3:0] NOP = 4'd0, MVI = 4'd1, MOVAR = 4'd2, MOVRA = 4'd3, ADD = 4'd4, SUB = 4'd5;
  localparam logic [3:0] ANA = 4'd6, ORA = 4'd7, XRA = 4'd8, INR = 4'd9, DCR = 4'd10, ADI = 4'd11;
  localparam logic [3:0] CMP = 4'd12, LDI = 4'd13, HLT = 4'd14, ILL = 4'd15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_pipeline_core_if #(.DATA_W(8),  .REG_AW(3)) a_if ();
  acc_pipeline_core_if #(.DATA_W(16), .REG_AW(4)) b_if ();

  logic [7:0]  a_acc, a_dbg_data;
  logic        a_cy, a_z, a_ret, a_halted, a_illegal;
  logic [7:0]  a_pc;
  logic [2:0]  a_dbg_addr;
  logic [15:0] b_acc, b_dbg_data;
  logic        b_cy, b_z, b_ret, b_halted, b_illegal;
  logic [3:0]  b_pc;
  logic [3:0]  b_dbg_addr;

  acc_pipeline_core #(.DATA_W(8), .REG_AW(3), .PC_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .instr(a_if),
    .acc(a_acc), .cy(a_cy), .z(a_z), .pc(a_pc), .retire_valid(a_ret),
    .halted(a_halted), .illegal(a_illegal), .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data)
  );

  acc_pipeline_core #(.DATA_W(16), .REG_AW(4), .PC_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .instr(b_if),
    .acc(b_acc), .cy(b_cy), .z(b_z), .pc(b_pc), .retire_valid(b_ret),
    .halted(b_halted), .illegal(b_illegal), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int a_ret_cnt;

  always @(negedge clk) begin
    if (!rst_n) a_ret_cnt <= 0;
    else if (a_ret) a_ret_cnt <= a_ret_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic [3:0] op, input logic [2:0] r, input logic [7:0] imm);
    a_if.instr_valid = 1'b1;
    a_if.instr_op    = op;
    a_if.instr_reg   = r;
    a_if.instr_imm   = imm;
    step();
  endtask

  task automatic idle_a(input int n);
    a_if.instr_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue_b(input logic [3:0] op, input logic [3:0] r, input logic [15:0] imm);
    b_if.instr_valid = 1'b1;
    b_if.instr_op    = op;
    b_if.instr_reg   = r;
    b_if.instr_imm   = imm;
    step();
  endtask

  task automatic idle_b(input int n);
    b_if.instr_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    a_if.instr_valid = 1'b0; a_if.instr_op = '0; a_if.instr_reg = '0; a_if.instr_imm = '0;
    b_if.instr_valid = 1'b0; b_if.instr_op = '0; b_if.instr_reg = '0; b_if.instr_imm = '0;
    a_dbg_addr = '0;
    b_dbg_addr = '0;

    // Reset values
    repeat (2) step();
    check("rst_acc", a_acc, 32'h0);
    check("rst_cy", a_cy, 32'h0);
    check("rst_z", a_z, 32'h0);
    check("rst_pc", a_pc, 32'h0);
    check("rst_ret", a_ret, 32'h0);
    check("rst_halted", a_halted, 32'h0);
    check("rst_illegal", a_illegal, 32'h0);
    check("rst_ready", a_if.instr_ready, 32'h1);
    check("rst_b_acc", b_acc, 32'h0);
    check("rst_b_pc", b_pc, 32'h0);
    rst_n = 1'b1;

    // Back-to-back LDI/MVI/ADD
    issue_a(LDI, 3'd0, 8'h05);
    issue_a(MVI, 3'd0, 8'h03);
    issue_a(ADD, 3'd0, 8'h00);
    idle_a(1);
    check("t1_acc", a_acc, 32'h08);
    check("t1_cy", a_cy, 32'h0);
    check("t1_z", a_z, 32'h0);
    check("t1_pc", a_pc, 32'd3);
    idle_a(2);
    check("t1_retires", a_ret_cnt, 32'd3);
    a_dbg_addr = 3'd0;
    #1 check("t1_dbg_r0", a_dbg_data, 32'h05);

    // S3 -> S2 bypass
    issue_a(MVI, 3'd0, 8'h01);
    issue_a(LDI, 3'd1, 8'hFF);
    issue_a(ADD, 3'd1, 8'h00);
    issue_a(INR, 3'd1, 8'h00);
    check("t2_add_acc", a_acc, 32'h00);
    check("t2_add_cy", a_cy, 32'h1);
    check("t2_add_z", a_z, 32'h1);
    issue_a(MOVAR, 3'd1, 8'h00);
    check("t2_inr_z", a_z, 32'h1);
    check("t2_inr_cy", a_cy, 32'h1);
    idle_a(1);
    check("t2_mov_acc", a_acc, 32'h00);
    check("t2_mov_cy", a_cy, 32'h1);
    idle_a(1);
    a_dbg_addr = 3'd1;
    #1 check("t2_dbg_r1", a_dbg_data, 32'h00);
    check("t2_pc", a_pc, 32'd8);

    // Compare / subtract / logic / immediate / decrement
    issue_a(LDI, 3'd2, 8'h20);
    issue_a(MVI, 3'd0, 8'h10);
    issue_a(CMP, 3'd2, 8'h00);
    issue_a(SUB, 3'd2, 8'h00);
    check("t3_cmp_acc", a_acc, 32'h10);
    check("t3_cmp_cy", a_cy, 32'h1);
    check("t3_cmp_z", a_z, 32'h0);
    issue_a(XRA, 3'd2, 8'h00);
    check("t3_sub_acc", a_acc, 32'hF0);
    check("t3_sub_cy", a_cy, 32'h1);
    issue_a(ORA, 3'd2, 8'h00);
    check("t3_xra_acc", a_acc, 32'hD0);
    check("t3_xra_cy", a_cy, 32'h0);
    issue_a(ANA, 3'd2, 8'h00);
    check("t3_ora_acc", a_acc, 32'hF0);
    issue_a(ADI, 3'd0, 8'hE0);
    check("t3_ana_acc", a_acc, 32'h20);
    issue_a(DCR, 3'd2, 8'h00);
    check("t3_adi_acc", a_acc, 32'h00);
    check("t3_adi_cy", a_cy, 32'h1);
    check("t3_adi_z", a_z, 32'h1);
    idle_a(1);
    check("t3_dcr_z", a_z, 32'h0);
    check("t3_dcr_cy", a_cy, 32'h1);
    check("t3_dcr_acc", a_acc, 32'h00);
    idle_a(2);
    a_dbg_addr = 3'd2;
    #1 check("t3_dbg_r2", a_dbg_data, 32'h1F);
    check("t3_pc", a_pc, 32'd17);

    // Illegal opcode, then HLT with a younger ADD held valid
    issue_a(MVI, 3'd0, 8'h42);
    issue_a(ILL, 3'd0, 8'h00);
    issue_a(HLT, 3'd0, 8'h00);
    check("t4_illegal", a_illegal, 32'h1);
    check("t4_ill_acc", a_acc, 32'h42);
    check("t4_ready_hlt_s1", a_if.instr_ready, 32'h0);
    check("t4_pc_hlt", a_pc, 32'd20);
    issue_a(ADD, 3'd0, 8'h00);
    check("t4_halted", a_halted, 32'h1);
    repeat (3) step();
    check("t4_ready_halted", a_if.instr_ready, 32'h0);
    check("t4_pc_frozen", a_pc, 32'd20);
    check("t4_acc_frozen", a_acc, 32'h42);
    check("t4_illegal_sticky", a_illegal, 32'h1);

    // Reset clears sticky flags; reset with MOV R3,A in S3 discards its write
    a_if.instr_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check("t5_halted_clr", a_halted, 32'h0);
    check("t5_illegal_clr", a_illegal, 32'h0);
    check("t5_pc_clr", a_pc, 32'd0);
    rst_n = 1'b1;
    issue_a(MVI, 3'd0, 8'h55);
    issue_a(MOVRA, 3'd3, 8'h00);
    idle_a(1);
    check("t5_pre_acc", a_acc, 32'h55);
    check("t5_pre_ret", a_ret, 32'h1);
    #2 rst_n = 1'b0;
    a_dbg_addr = 3'd3;
    #1;
    check("t5_dbg_r3", a_dbg_data, 32'h00);
    check("t5_acc", a_acc, 32'h00);
    check("t5_ret", a_ret, 32'h0);
    check("t5_pc", a_pc, 32'd0);
    step();
    rst_n = 1'b1;
    idle_a(2);
    check("t5_dbg_r3_after", a_dbg_data, 32'h00);
    check("t5_ret_after", a_ret, 32'h0);

    // Wide instance: carry out of bit 15 and pc wrap
    issue_b(LDI, 4'd15, 16'hFFFF);
    issue_b(MVI, 4'd0, 16'h0001);
    issue_b(ADD, 4'd15, 16'h0000);
    check("t6_b_pc3", b_pc, 32'd3);
    idle_b(1);
    check("t6_b_acc", b_acc, 32'h0000);
    check("t6_b_cy", b_cy, 32'h1);
    check("t6_b_z", b_z, 32'h1);
    for (int i = 0; i < 12; i++) issue_b(NOP, 4'd0, 16'h0000);
    check("t6_b_pc15", b_pc, 32'd15);
    issue_b(NOP, 4'd0, 16'h0000);
    idle_b(1);
    check("t6_b_pc_wrap", b_pc, 32'd0);
    b_dbg_addr = 4'd15;
    #1 check("t6_b_dbg_r15", b_dbg_data, 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/acc_pipeline_core.md
Name: acc_pipeline_core

Overview:
Parametrised successor to the fixed 8-bit 8085-style pipelined core: accumulator machine with generic DATA_W datapath, 2**REG_AW register file, CY/Z flags and instruction count (pc).
Instructions arrive on a valid/ready stream from an external fetch unit.
Execution is a 3-stage in-order pipeline (S1 decode latch, S2 execute, S3 register writeback) with S3->S2 bypass, HLT and illegal-opcode detection.
Has a debug register read port so benches stop poking hierarchical register-file paths.

Parameters:
DATA_W, 8, datapath/accumulator/register width (>=4)
REG_AW, 3, register address width; NREGS = 2**REG_AW
PC_W, 8, instruction counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  core accepts instruction this cycle
instr_op  in  4  opcode
instr_reg  in  REG_AW  register operand index
instr_imm  in  DATA_W  immediate
acc  out  DATA_W  accumulator
cy  out  1  carry/borrow flag
z  out  1  zero flag
pc  out  PC_W  count of accepted instructions, mod 2**PC_W
retire_valid  out  1  one-cycle pulse per instruction leaving S3
halted  out  1  sticky, HLT executed
illegal  out  1  sticky, opcode 15 executed
dbg_addr  in  REG_AW  debug read index
dbg_data  out  DATA_W  combinational architectural R[dbg_addr], no bypass

Behaviour:
- Reset (async assert, sync release): acc=0, cy=0, z=0, pc=0, all R[i]=0, S1/S2/S3 valid=0, halted=0, illegal=0, retire_valid=0. Reset mid-operation drops in-flight instructions; their pending RF writes are discarded.
- Accept: instr_valid && instr_ready at edge k latches the instruction into S1 and sets pc=pc+1 (wraps). instr_ready = !halted && !(HLT in S1 or S2). Inputs while ready=0 are ignored; pc frozen.
- Execute: S2 executes at edge k+1, updating acc/cy/z and loading S3. acc/flags are visible 1 cycle after acceptance.
- Writeback: S3 writes the RF at edge k+2. retire_valid is high in the cycle after edge k+2.
- No stalls except HLT. Back-to-back issue gives 1 instruction/cycle.
- Operand R[r] in S2: if S3 is valid, writes a register, and S3.reg==r, use S3 data; else use the RF. Distance-2 producers are already in the RF.
- Opcodes (A=acc, R=operand, all arithmetic mod 2**DATA_W):
  - 0 NOP
  - 1 MVI A=imm; flags unchanged
  - 2 MOV A=R; flags unchanged
  - 3 MOV R[r]=A
  - 4 ADD A=A+R; cy=carry out of bit DATA_W-1; z=(A'==0)
  - 5 SUB A=A-R; cy=(A<R unsigned); z
  - 6 ANA, 7 ORA, 8 XRA: A=A op R; cy=0; z
  - 9 INR R[r]=R+1; 10 DCR R[r]=R-1: z from result, cy unchanged, acc unchanged
  - 11 ADI A=A+imm; flags as ADD
  - 12 CMP: flags as SUB, A unchanged
  - 13 LDI R[r]=imm; flags unchanged
  - 14 HLT: halted=1 at its S2 edge; S3 retires it as NOP
  - 15 illegal: executes as NOP, illegal=1 at S2 edge
- Only ops 3, 9, 10, 13 write the RF.
- Flags only change via opcodes 4-12 as listed.
- Halted core: pipeline drains normally (older instructions retire). halted/illegal clear only on reset.

Test Plan:
- Reset, then LDI R0,0x05; MVI A,0x03; ADD R0 back-to-back -> acc=0x08, cy=0, z=0 one cycle after ADD accepted; pc=3; three retire pulses.
- Bypass: A=0x01; LDI R1,0xFF then ADD R1 next cycle -> A=0x00, cy=1, z=1. Then INR R1; MOV A,R1 -> A=0x00, dbg R1=0x00, cy still 1.
- A=0x10, R2=0x20: CMP R2 -> z=0, cy=1, A=0x10. SUB R2 -> A=0xF0, cy=1. XRA R2 -> A=0xD0, cy=0.
- HLT followed by ADD R0 held valid -> ready low from cycle after HLT accept; halted=1; ADD never executes; pc frozen. Opcode 15 -> illegal=1, acc unchanged.
- DATA_W=16, REG_AW=4, PC_W=4: LDI R15,0xFFFF; MVI A,1; ADD R15 -> A=0x0000, cy=1, z=1. 16 accepts -> pc wraps to 0.
- rst_n low while MOV R3,A (A=0x55) is in S3 -> dbg R3=0, acc=0, retire_valid=0, all outputs at reset values immediately.
